lcd_bus_ctrl: RTL and testbench

- Hardware HD44780-style character-LCD bus sequencer on the receiving side of the core's `io_lcd_o` register.
- Software writes one command/data byte per request and flips a GO toggle bit. The block generates RS/RW/DATA setup, the EN pulse, hold, and the controller execution wait.
- Exposes a status word the core reads back through its input-mux space.
- Sits between the single-cycle core's LSU output register and the board LCD pins.

---
 rtl/lcd_bus_ctrl_pkg.sv | 42 ++++
 rtl/lcd_bus_ctrl_if.sv | 22 ++
 rtl/lcd_bus_ctrl_timer.sv | 32 +++
 rtl/lcd_bus_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_lcd_bus_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/lcd_bus_ctrl_pkg.sv
// lcd_pkg: shared types and constants for the HD44780-style LCD bus sequencer.
//   - lcd_state_e : sequencer FSM states
//   - REG_* / STAT_* : bit positions in the core LCD register and status word
//   - OP_CLEAR / OP_HOME : opcodes that need the long execution wait
//   - INIT_CMDS : power-on command list (used when LCD_INIT_SEQ_EN is defined)
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        EN_HI,
        HOLD,
        EXEC,
        INIT_WAIT
    } lcd_state_e;

    // lcd_reg_i fields
    localparam int REG_ON_BIT   = 31;
    localparam int REG_GO_BIT   = 30;
    localparam int REG_RS_BIT   = 9;
    localparam int REG_RW_BIT   = 8;
    localparam int REG_DATA_LSB = 0;

    // lcd_status_o fields
    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_INIT_BIT = 1;
    localparam int STAT_CNT_LSB  = 8;

    localparam logic [7:0] OP_CLEAR = 8'h01;
    localparam logic [7:0] OP_HOME  = 8'h02;  // 0x03 is also "home"

    // Function set 8-bit/2-line, display on, clear, entry mode increment.
    localparam int INIT_LEN   = 4;
    localparam int INIT_IDX_W = 2;
    localparam logic [INIT_LEN-1:0][7:0] INIT_CMDS = {8'h06, 8'h01, 8'h0C, 8'h38};

    // Clear and home are instructions (RS=0) that take the long wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == OP_CLEAR) || (data[7:1] == OP_HOME[7:1]));
    endfunction

endpackage

// File: rtl/lcd_bus_ctrl_if.sv
// lcd_bus_ctrl_if: core-side register, status word and board LCD pins.
//   master : core / test side (drives lcd_reg_i, observes everything else)
//   slave  : lcd_bus_ctrl
interface lcd_bus_ctrl_if;
    logic [31:0] lcd_reg_i;     // core LCD register
    logic [31:0] lcd_status_o;  // {16'b0, done_cnt, 6'b0, init_done, busy}
    logic        lcd_on_o;
    logic        lcd_en_o;
    logic        lcd_rs_o;
    logic        lcd_rw_o;
    logic [7:0]  lcd_data_o;

    modport master (
        output lcd_reg_i,
        input  lcd_status_o, lcd_on_o, lcd_en_o, lcd_rs_o, lcd_rw_o, lcd_data_o
    );

    modport slave (
        input  lcd_reg_i,
        output lcd_status_o, lcd_on_o, lcd_en_o, lcd_rs_o, lcd_rw_o, lcd_data_o
    );
endinterface

// File: rtl/lcd_bus_ctrl_timer.sv
// lcd_timer: loadable down-counter for the phase timing of lcd_bus_ctrl.
//   clk_i, rst_ni : clock, async active-low reset (counter -> RST_VAL)
//   load_i        : load load_val_i this cycle (overrides counting)
//   load_val_i    : value to load; a phase of N cycles loads N-1
//   zero_o        : counter currently 0 (it then stays at 0)
module lcd_timer #(
    parameter int               CNT_W   = 17,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= RST_VAL;
        else         cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/lcd_bus_ctrl.sv
// lcd_bus_ctrl: HD44780-style character-LCD bus sequencer.
// Software writes RS/DATA into lcd_reg_i and flips the GO bit; the block then
// drives setup, an EN pulse, hold and the controller execution wait.
//   clk_i, rst_ni : clock, async active-low reset
//   bus (slave)   : lcd_reg_i in; lcd_status_o, lcd_on_o, lcd_en_o,
//                   lcd_rs_o, lcd_rw_o (always 0), lcd_data_o out
// Build option: define LCD_INIT_SEQ_EN to run the power-on init sequence
// (T_PWR_ON wait, then INIT_CMDS) before serving the core. Without it,
// init_done reads 1 and the FSM starts in IDLE.
module lcd_bus_ctrl
    import lcd_pkg::*;
#(
    parameter int T_SETUP  = 4,
    parameter int T_EN     = 12,
    parameter int T_HOLD   = 4,
    parameter int T_EXEC   = 2000,
    parameter int T_CLEAR  = 82000,
`ifdef LCD_INIT_SEQ_EN
    parameter int T_PWR_ON = 750000,
    parameter int CNT_W    = 20
`else
    parameter int CNT_W    = 17
`endif
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    lcd_bus_ctrl_if.slave bus
);
    lcd_state_e       state_q, state_d;
    logic             go_q, go_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;
    logic             on_q, on_d;
    logic [7:0]       done_cnt_q, done_cnt_d;
    logic             tmr_load, tmr_zero;
    logic [CNT_W-1:0] tmr_val;
    logic             init_done;

`ifdef LCD_INIT_SEQ_EN
    localparam logic [CNT_W-1:0] TMR_RST = CNT_W'(T_PWR_ON - 1);
    localparam lcd_state_e       ST_RST  = INIT_WAIT;
    logic                  init_done_q, init_done_d;
    logic [INIT_IDX_W-1:0] init_idx_q, init_idx_d, init_idx_nxt;
    assign init_done    = init_done_q;
    assign init_idx_nxt = init_idx_q + 1'b1;
`else
    localparam logic [CNT_W-1:0] TMR_RST = '0;
    localparam lcd_state_e       ST_RST  = IDLE;
    assign init_done = 1'b1;
`endif

    // RW is forced to write; the other spare register bits are don't-care.
    logic unused_reg_bits;
    assign unused_reg_bits = ^{bus.lcd_reg_i[29:10], bus.lcd_reg_i[REG_RW_BIT]};

    lcd_timer #(.CNT_W(CNT_W), .RST_VAL(TMR_RST)) u_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d    = state_q;
        go_d       = go_q;
        rs_d       = rs_q;
        data_d     = data_q;
        done_cnt_d = done_cnt_q;
        on_d       = bus.lcd_reg_i[REG_ON_BIT];
        tmr_load   = 1'b0;
        tmr_val    = '0;
`ifdef LCD_INIT_SEQ_EN
        init_done_d = init_done_q;
        init_idx_d  = init_idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.lcd_reg_i[REG_GO_BIT] != go_q) begin
                    go_d     = bus.lcd_reg_i[REG_GO_BIT];
                    rs_d     = bus.lcd_reg_i[REG_RS_BIT];
                    data_d   = bus.lcd_reg_i[REG_DATA_LSB +: 8];
                    state_d  = SETUP;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(T_SETUP - 1);
                end
            end
            SETUP: if (tmr_zero) begin
                state_d  = EN_HI;
                tmr_load = 1'b1;
                tmr_val  = CNT_W'(T_EN - 1);
            end
            EN_HI: if (tmr_zero) begin
                state_d  = HOLD;
                tmr_load = 1'b1;
                tmr_val  = CNT_W'(T_HOLD - 1);
            end
            HOLD: if (tmr_zero) begin
                state_d  = EXEC;
                tmr_load = 1'b1;
                tmr_val  = is_long_cmd(rs_q, data_q) ? CNT_W'(T_CLEAR - 1)
                                                     : CNT_W'(T_EXEC - 1);
            end
            EXEC: if (tmr_zero) begin
`ifdef LCD_INIT_SEQ_EN
                if (!init_done_q) begin
                    // Init commands chain straight into the next SETUP so a
                    // pending GO cannot slip in between them.
                    if (init_idx_q == INIT_IDX_W'(INIT_LEN - 1)) begin
                        init_done_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        init_idx_d = init_idx_nxt;
                        data_d     = INIT_CMDS[init_idx_nxt];
                        rs_d       = 1'b0;
                        state_d    = SETUP;
                        tmr_load   = 1'b1;
                        tmr_val    = CNT_W'(T_SETUP - 1);
                    end
                end else begin
                    state_d    = IDLE;
                    done_cnt_d = done_cnt_q + 8'd1;
                end
`else
                state_d    = IDLE;
                done_cnt_d = done_cnt_q + 8'd1;
`endif
            end
            INIT_WAIT: begin
`ifdef LCD_INIT_SEQ_EN
                if (tmr_zero) begin
                    data_d   = INIT_CMDS[0];
                    rs_d     = 1'b0;
                    state_d  = SETUP;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(T_SETUP - 1);
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
        // EN and busy come straight from the next state so the pins are flops.
        en_d   = (state_d == EN_HI);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_RST;
            go_q       <= 1'b0;
            rs_q       <= 1'b0;
            data_q     <= 8'd0;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            on_q       <= 1'b0;
            done_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            go_q       <= go_d;
            rs_q       <= rs_d;
            data_q     <= data_d;
            en_q       <= en_d;
            busy_q     <= busy_d;
            on_q       <= on_d;
            done_cnt_q <= done_cnt_d;
        end
    end

`ifdef LCD_INIT_SEQ_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            init_done_q <= 1'b0;
            init_idx_q  <= '0;
        end else begin
            init_done_q <= init_done_d;
            init_idx_q  <= init_idx_d;
        end
    end
`endif

    always_comb begin
        bus.lcd_status_o                       = '0;
        bus.lcd_status_o[STAT_BUSY_BIT]        = busy_q;
        bus.lcd_status_o[STAT_INIT_BIT]        = init_done;
        bus.lcd_status_o[STAT_CNT_LSB +: 8]    = done_cnt_q;
    end

    assign bus.lcd_on_o   = on_q;
    assign bus.lcd_en_o   = en_q;
    assign bus.lcd_rs_o   = rs_q;
    assign bus.lcd_rw_o   = 1'b0;
    assign bus.lcd_data_o = data_q;
endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// Directed bench for lcd_bus_ctrl (default build) with short timing:
// T_SETUP=2, T_EN=3, T_HOLD=2, T_EXEC=10, T_CLEAR=50.
// Inputs change and outputs are sampled at the falling clock edge.
module tb_lcd_bus_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lcd_bus_ctrl_if bus ();

    lcd_bus_ctrl #(
        .T_SETUP (2),
        .T_EN    (3),
        .T_HOLD  (2),
        .T_EXEC  (10),
        .T_CLEAR (50),
        .CNT_W   (17)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic       rs;
        logic       rw;
        logic [7:0] data;
        int         exp_busy;   // busy cycles, accept+1 .. back in IDLE
        logic [7:0] exp_cnt;    // done count after the transfer
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   en_pulses = 0;
    logic en_prev = 1'b0;
    logic go = 1'b0;
    logic on = 1'b0;
    logic [7:0] exp_cnt = 8'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (bus.lcd_en_o && !en_prev) en_pulses++;
        en_prev = bus.lcd_en_o;
    endtask

    task automatic drive(input logic rs, input logic rw, input logic [7:0] data);
        bus.lcd_reg_i = {on, go, 20'd0, rs, rw, data};
    endtask

    // Launch one transfer and follow it until busy drops again.
    task automatic run_vec(input vec_t v);
        int   busy_first = -1, busy_len = 0, en_first = -1, en_len = 0;
        logic rw_seen = 1'b0;
        logic [7:0] data_c1 = 8'd0;
        logic rs_c1 = 1'b0;
        bit   done = 1'b0;
        go = ~go;
        drive(v.rs, v.rw, v.data);
        for (int c = 1; c <= 200; c++) begin
            step();
            if (c == 1) begin
                rs_c1   = bus.lcd_rs_o;
                data_c1 = bus.lcd_data_o;
            end
            rw_seen |= bus.lcd_rw_o;
            if (bus.lcd_en_o) begin
                if (en_first < 0) en_first = c;
                en_len++;
            end
            if (bus.lcd_status_o[0]) begin
                if (busy_first < 0) busy_first = c;
                busy_len++;
            end else if (busy_first >= 0) begin
                done = 1'b1;
                break;
            end
        end
        chk("xfer_timeout", 32'(done), 32'd1);
        chk("rs_after_accept", 32'(rs_c1), 32'(v.rs));
        chk("data_after_accept", 32'(data_c1), 32'(v.data));
        chk("busy_start", 32'(busy_first), 32'd1);
        chk("busy_len", 32'(busy_len), 32'(v.exp_busy));
        chk("en_start", 32'(en_first), 32'd3);
        chk("en_len", 32'(en_len), 32'd3);
        chk("rw_zero", 32'(rw_seen), 32'd0);
        chk("status_after", bus.lcd_status_o, {16'd0, v.exp_cnt, 8'h02});
        chk("data_hold_idle", 32'(bus.lcd_data_o), 32'(v.data));
    endtask

    vec_t vecs [7];

    initial begin
        int p0;
        bit ok;
        vecs[0] = '{rs: 1'b1, rw: 1'b0, data: 8'h41, exp_busy: 17, exp_cnt: 8'd1};
        vecs[1] = '{rs: 1'b0, rw: 1'b0, data: 8'h01, exp_busy: 57, exp_cnt: 8'd2};
        vecs[2] = '{rs: 1'b0, rw: 1'b1, data: 8'h04, exp_busy: 17, exp_cnt: 8'd3};
        vecs[3] = '{rs: 1'b0, rw: 1'b0, data: 8'h02, exp_busy: 57, exp_cnt: 8'd4};
        vecs[4] = '{rs: 1'b0, rw: 1'b1, data: 8'h03, exp_busy: 57, exp_cnt: 8'd5};
        vecs[5] = '{rs: 1'b1, rw: 1'b0, data: 8'h01, exp_busy: 17, exp_cnt: 8'd6};
        vecs[6] = '{rs: 1'b0, rw: 1'b0, data: 8'h00, exp_busy: 17, exp_cnt: 8'd7};

        // Reset state
        rst_n = 1'b0;
        bus.lcd_reg_i = 32'd0;
        repeat (3) step();
        chk("rst_status", bus.lcd_status_o, 32'h0000_0002);
        chk("rst_en", 32'(bus.lcd_en_o), 32'd0);
        chk("rst_pins", {22'd0, bus.lcd_on_o, bus.lcd_rs_o, bus.lcd_data_o}, 32'd0);
        rst_n = 1'b1;
        repeat (3) step();
        chk("idle_status", bus.lcd_status_o, 32'h0000_0002);

        // Table of single transfers, ON held high
        on = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        step();
        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
            step();
        end
        exp_cnt = 8'd7;

        // Back-to-back: second toggle while EN is high
        p0 = en_pulses;
        go = ~go;
        drive(1'b1, 1'b0, 8'h30);
        for (int c = 1; c <= 40; c++) begin
            step();
            if (c == 3) chk("b2b_en_high", 32'(bus.lcd_en_o), 32'd1);
            if (c == 4) begin go = ~go; drive(1'b1, 1'b0, 8'h30); end
            if (c == 18) chk("b2b_gap_idle", 32'(bus.lcd_status_o[0]), 32'd0);
            if (c == 19) chk("b2b_second_busy", 32'(bus.lcd_status_o[0]), 32'd1);
            if (c == 35) chk("b2b_second_last", 32'(bus.lcd_status_o[0]), 32'd1);
        end
        exp_cnt = exp_cnt + 8'd2;
        chk("b2b_pulses", 32'(en_pulses - p0), 32'd2);
        chk("b2b_status", bus.lcd_status_o, {16'd0, exp_cnt, 8'h02});

        // Double toggle while busy cancels out
        p0 = en_pulses;
        go = ~go;
        drive(1'b1, 1'b0, 8'h31);
        for (int c = 1; c <= 40; c++) begin
            step();
            if (c == 4 || c == 6) begin go = ~go; drive(1'b1, 1'b0, 8'h31); end
            if (c == 19) chk("dbl_no_second", 32'(bus.lcd_status_o[0]), 32'd0);
        end
        exp_cnt = exp_cnt + 8'd1;
        chk("dbl_pulses", 32'(en_pulses - p0), 32'd1);
        chk("dbl_status", bus.lcd_status_o, {16'd0, exp_cnt, 8'h02});

        // Reset during EN_HI with GO left at 1
        go = ~go;
        chk("rst_go_is_one", 32'(go), 32'd1);
        drive(1'b1, 1'b0, 8'h55);
        repeat (4) step();
        chk("mid_en_high", 32'(bus.lcd_en_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_en", 32'(bus.lcd_en_o), 32'd0);
        chk("mid_rst_pins", {22'd0, bus.lcd_on_o, bus.lcd_rs_o, bus.lcd_data_o}, 32'd0);
        chk("mid_rst_status", bus.lcd_status_o, 32'h0000_0002);
        step();
        rst_n = 1'b1;
        p0 = en_pulses;
        ok = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            step();
            if (c == 1) chk("post_rst_busy", 32'(bus.lcd_status_o[0]), 32'd1);
            if (c > 1 && !bus.lcd_status_o[0]) begin ok = 1'b1; break; end
        end
        chk("post_rst_timeout", 32'(ok), 32'd1);
        chk("post_rst_pulses", 32'(en_pulses - p0), 32'd1);
        chk("post_rst_status", bus.lcd_status_o, 32'h0000_0102);
        chk("post_rst_data", 32'(bus.lcd_data_o), 32'h55);

        // ON passthrough, no transfer
        step();
        p0 = en_pulses;
        on = 1'b0;
        drive(1'b1, 1'b0, 8'h55);
        chk("on_old_value", 32'(bus.lcd_on_o), 32'd1);
        step();
        chk("on_fall", 32'(bus.lcd_on_o), 32'd0);
        on = 1'b1;
        drive(1'b1, 1'b0, 8'h55);
        step();
        chk("on_rise", 32'(bus.lcd_on_o), 32'd1);
        repeat (10) step();
        chk("on_no_pulse", 32'(en_pulses - p0), 32'd0);
        chk("on_status", bus.lcd_status_o, 32'h0000_0102);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
